// File: rtl/xup_piso_vector.sv
// Parallel-in, serial-out unloader: captures a SIZE-bit word on load/ready and
// presents it one bit at a time on sout, advancing only when the consumer strobes en.
module xup_piso_vector #(
   parameter int SIZE      = 4,
   parameter int DELAY     = 3,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [SIZE-1:0] d,
   input  logic            load,
   output logic            ready,
   output logic            sout,
   output logic            sout_valid,
   input  logic            en,
   output logic            done
);

   localparam int CW = $clog2(SIZE + 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t          r_state;
   logic [SIZE-1:0] r_shift;
   logic [CW-1:0]   r_count;
   logic            r_sout;
   logic            r_valid;
   logic            r_ready;
   logic            r_done;

   state_t          w_stateNext;
   logic [SIZE-1:0] w_shiftNext;
   logic [CW-1:0]   w_countNext;
   logic            w_soutNext;
   logic            w_validNext;
   logic            w_readyNext;
   logic            w_doneNext;
   logic [SIZE-1:0] w_shifted;

   // DELAY only matters to timing-annotated simulation models; it has no logic here.
   if (DELAY < 0) begin : gNegativeDelay
   end

   // The current bit always sits at the outgoing end, so one shift exposes the next.
   assign w_shifted = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

   always_comb begin
      w_stateNext = r_state;
      w_shiftNext = r_shift;
      w_countNext = r_count;
      w_soutNext  = r_sout;
      w_validNext = r_valid;
      w_readyNext = r_ready;
      w_doneNext  = 1'b0;
      case (r_state)
         IDLE: begin
            if (load) begin
               w_shiftNext = d;
               w_soutNext  = MSB_FIRST ? d[SIZE-1] : d[0];
               w_validNext = 1'b1;
               w_readyNext = 1'b0;
               w_countNext = CW'(SIZE - 1);
               w_stateNext = SHIFT;
            end
         end
         SHIFT: begin
            if (en) begin
               if (r_count != '0) begin
                  w_shiftNext = w_shifted;
                  w_soutNext  = MSB_FIRST ? w_shifted[SIZE-1] : w_shifted[0];
                  w_countNext = r_count - 1'b1;
               end else begin
                  w_shiftNext = '0;
                  w_soutNext  = 1'b0;
                  w_validNext = 1'b0;
                  w_readyNext = 1'b1;
                  w_doneNext  = 1'b1;
                  w_stateNext = IDLE;
               end
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_readyNext = 1'b1;
            w_validNext = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_count <= '0;
         r_sout  <= 1'b0;
         r_valid <= 1'b0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_shift <= w_shiftNext;
         r_count <= w_countNext;
         r_sout  <= w_soutNext;
         r_valid <= w_validNext;
         r_ready <= w_readyNext;
         r_done  <= w_doneNext;
      end
   end

   assign ready      = r_ready;
   assign sout       = r_sout;
   assign sout_valid = r_valid;
   assign done       = r_done;

endmodule

// File: tb/tb_xup_piso_vector.sv
// Bench for xup_piso_vector: an MSB-first and an LSB-first SIZE=4 instance checked by
// scoreboard monitors, plus a SIZE=1 instance checked directly.
module tb_xup_piso_vector;

   typedef struct packed {
      logic b;
      logic last;
   } exp_t;

   logic clk;
   logic reset;

   logic [3:0] aD, bD;
   logic       aLoad, aEn, aReady, aSout, aValid, aDone;
   logic       bLoad, bEn, bReady, bSout, bValid, bDone;
   logic [0:0] cD;
   logic       cLoad, cEn, cReady, cSout, cValid, cDone;

   exp_t qA[$];
   exp_t qB[$];
   bit   pendA, pendB;
   bit   monEn;
   int   checks;
   int   errors;

   xup_piso_vector #(.SIZE(4), .DELAY(3), .MSB_FIRST(1'b1)) uMsb (
      .clk(clk), .reset(reset), .d(aD), .load(aLoad), .ready(aReady),
      .sout(aSout), .sout_valid(aValid), .en(aEn), .done(aDone)
   );

   xup_piso_vector #(.SIZE(4), .DELAY(3), .MSB_FIRST(1'b0)) uLsb (
      .clk(clk), .reset(reset), .d(bD), .load(bLoad), .ready(bReady),
      .sout(bSout), .sout_valid(bValid), .en(bEn), .done(bDone)
   );

   xup_piso_vector #(.SIZE(1), .DELAY(3), .MSB_FIRST(1'b1)) uOne (
      .clk(clk), .reset(reset), .d(cD), .load(cLoad), .ready(cReady),
      .sout(cSout), .sout_valid(cValid), .en(cEn), .done(cDone)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic actual, input logic required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=%b required=%b at %0t", name, actual, required, $time);
      end
   endtask

   // Advance a number of rising edges, returning just after the last one.
   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected bits are listed in hand-written transmission order, first bit leftmost.
   task automatic pushWord(input bit toB, input logic [3:0] order);
      exp_t e;
      for (int i = 3; i >= 0; i--) begin
         e.b    = order[i];
         e.last = (i == 0);
         if (toB) qB.push_back(e);
         else     qA.push_back(e);
      end
   endtask

   // Monitors: done must match the previous cycle's final acceptance, and any
   // valid bit must equal the head of the queue until en retires it.
   always @(negedge clk) begin
      if (monEn) begin
         checkOutput("doneA", aDone, pendA);
         pendA = 1'b0;
         if (aValid) begin
            if (qA.size() == 0) begin
               checkOutput("unexpectedValidA", aValid, 1'b0);
            end else begin
               checkOutput("soutA", aSout, qA[0].b);
               if (aEn) begin
                  pendA = qA[0].last;
                  void'(qA.pop_front());
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (monEn) begin
         checkOutput("doneB", bDone, pendB);
         pendB = 1'b0;
         if (bValid) begin
            if (qB.size() == 0) begin
               checkOutput("unexpectedValidB", bValid, 1'b0);
            end else begin
               checkOutput("soutB", bSout, qB[0].b);
               if (bEn) begin
                  pendB = qB[0].last;
                  void'(qB.pop_front());
               end
            end
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      monEn  = 1'b0;
      pendA  = 1'b0;
      pendB  = 1'b0;

      // Reset held with load and en asserted must leave every instance idle.
      reset = 1'b1;
      aD = 4'hF; aLoad = 1'b1; aEn = 1'b1;
      bD = 4'hF; bLoad = 1'b1; bEn = 1'b1;
      cD = 1'b1; cLoad = 1'b1; cEn = 1'b1;
      applyStimulus(2);
      checkOutput("rstReadyA", aReady, 1'b1);
      checkOutput("rstValidA", aValid, 1'b0);
      checkOutput("rstSoutA", aSout, 1'b0);
      checkOutput("rstDoneA", aDone, 1'b0);
      checkOutput("rstReadyB", bReady, 1'b1);
      checkOutput("rstValidB", bValid, 1'b0);
      checkOutput("rstValidC", cValid, 1'b0);
      reset = 1'b0;
      aLoad = 1'b0; aEn = 1'b0;
      bLoad = 1'b0; bEn = 1'b0;
      cLoad = 1'b0; cEn = 1'b0;
      applyStimulus(1);
      checkOutput("idleValidA", aValid, 1'b0);
      checkOutput("idleReadyA", aReady, 1'b1);
      monEn = 1'b1;

      // MSB-first 1011 with en held high: 1,0,1,1 then done.
      aD = 4'b1011; aLoad = 1'b1;
      pushWord(1'b0, 4'b1011);
      applyStimulus(1);
      checkOutput("loadReadyA", aReady, 1'b0);
      aLoad = 1'b0; aEn = 1'b1;
      applyStimulus(4);
      checkOutput("w1DoneA", aDone, 1'b1);
      checkOutput("w1ReadyA", aReady, 1'b1);
      checkOutput("w1ValidA", aValid, 1'b0);
      aEn = 1'b0;
      applyStimulus(1);
      checkOutput("w1DoneClearA", aDone, 1'b0);

      // LSB-first 1011 with a three-cycle stall after the second bit: 1,1,0,1.
      bD = 4'b1011; bLoad = 1'b1;
      pushWord(1'b1, 4'b1101);
      applyStimulus(1);
      bLoad = 1'b0; bEn = 1'b1;
      applyStimulus(2);
      bEn = 1'b0;
      applyStimulus(3);
      checkOutput("stallValidB", bValid, 1'b1);
      checkOutput("stallSoutB", bSout, 1'b0);
      bEn = 1'b1;
      applyStimulus(2);
      checkOutput("stallDoneB", bDone, 1'b1);
      bEn = 1'b0;
      applyStimulus(1);
      checkOutput("stallDoneClearB", bDone, 1'b0);

      // Load while busy, with d cleared mid-word: original word must finish intact.
      aD = 4'b1011; aLoad = 1'b1;
      pushWord(1'b0, 4'b1011);
      applyStimulus(1);
      aLoad = 1'b0; aEn = 1'b1;
      applyStimulus(1);
      aD = 4'b0000; aLoad = 1'b1;
      applyStimulus(1);
      aLoad = 1'b0;
      applyStimulus(2);
      checkOutput("busyDoneA", aDone, 1'b1);
      aEn = 1'b0;
      applyStimulus(1);
      checkOutput("busyNoSecondWordA", aValid, 1'b0);

      // Back-to-back: second load lands in the done cycle where ready is already 1.
      aD = 4'b1100; aLoad = 1'b1;
      pushWord(1'b0, 4'b1100);
      applyStimulus(1);
      aLoad = 1'b0; aEn = 1'b1;
      applyStimulus(4);
      checkOutput("b2bReadyA", aReady, 1'b1);
      aD = 4'b0011; aLoad = 1'b1;
      pushWord(1'b0, 4'b0011);
      applyStimulus(1);
      checkOutput("b2bValidA", aValid, 1'b1);
      aLoad = 1'b0;
      applyStimulus(4);
      checkOutput("b2bDone2A", aDone, 1'b1);
      aEn = 1'b0;
      applyStimulus(1);

      // Reset after two accepted bits aborts the word without a done pulse.
      aD = 4'b1011; aLoad = 1'b1;
      pushWord(1'b0, 4'b1011);
      applyStimulus(1);
      aLoad = 1'b0; aEn = 1'b1;
      applyStimulus(2);
      reset = 1'b1; aEn = 1'b0;
      applyStimulus(1);
      qA.delete();
      checkOutput("abortReadyA", aReady, 1'b1);
      checkOutput("abortValidA", aValid, 1'b0);
      checkOutput("abortDoneA", aDone, 1'b0);
      reset = 1'b0;
      applyStimulus(1);
      checkOutput("abortNoDoneA", aDone, 1'b0);
      aD = 4'b0110; aLoad = 1'b1;
      pushWord(1'b0, 4'b0110);
      applyStimulus(1);
      aLoad = 1'b0; aEn = 1'b1;
      applyStimulus(4);
      checkOutput("freshDoneA", aDone, 1'b1);
      aEn = 1'b0;

      // SIZE=1: one load gives the bit, one en gives done.
      cD = 1'b1; cLoad = 1'b1;
      applyStimulus(1);
      cLoad = 1'b0;
      checkOutput("oneValidC", cValid, 1'b1);
      checkOutput("oneSoutC", cSout, 1'b1);
      checkOutput("oneReadyC", cReady, 1'b0);
      cEn = 1'b1;
      applyStimulus(1);
      cEn = 1'b0;
      checkOutput("oneDoneC", cDone, 1'b1);
      checkOutput("oneReadyAfterC", cReady, 1'b1);
      checkOutput("oneValidAfterC", cValid, 1'b0);
      cD = 1'b0; cLoad = 1'b1;
      applyStimulus(1);
      cLoad = 1'b0;
      checkOutput("zeroValidC", cValid, 1'b1);
      checkOutput("zeroSoutC", cSout, 1'b0);
      applyStimulus(2);
      checkOutput("zeroHoldC", cValid, 1'b1);

      checkOutput("drainedA", qA.size() == 0, 1'b1);
      checkOutput("drainedB", qB.size() == 0, 1'b1);
      monEn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
